// File: rtl/i2c_master.sv
// Purpose : single-master I2C initiator; one START / addr+R/W / one data byte / STOP per run.
// Latency : 80*CLK_DIV cycles busy-rise to done (44*CLK_DIV on address NACK), plus any clock stretch.
// Backpr. : start is ignored while busy=1; a target holding SCL low stalls the bit frame.
//
// Ports: sys_clk/sys_rst_n clock and async active-low reset; start/rw/addr/wdata request;
//        rdata/busy/done/ack_err status; SCL/SDA open-drain bus lines (driven 0 or z only).
module i2c_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        SCL,
    inout  wire        SDA
);
    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_WDATA, S_WACK, S_RDATA, S_MACK, S_STOP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;
    logic [1:0]    qtr_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q, wdata_q;
    logic          rw_q;
    logic          scl_s1, scl_s2, sda_s1, sda_s2;
    logic          scl_oe_q, sda_oe_q, scl_oe_d, sda_oe_d;
    logic          accept, stall, q_tick, frame_end;

    // Open-drain pads: only ever pull low or release.
    assign SCL = scl_oe_q ? 1'b0 : 1'bz;
    assign SDA = sda_oe_q ? 1'b0 : 1'bz;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign accept    = start && !busy;
    // Q2 may not end until the released SCL is seen high (clock stretching).
    assign stall     = (qtr_q == 2'd2) && !scl_s2;
    assign q_tick    = busy && (div_q == DIV_LAST) && !stall;
    assign frame_end = q_tick && (qtr_q == 2'd3);

    // Bus inputs synchronised; idle bus reads high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
        end
    end

    // Quarter-bit divider. While stalled in Q2 it parks on its last count, so
    // the quarter advances on the cycle after SCL is seen high and Q3 restarts from 0.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q <= '0;
            qtr_q <= 2'd0;
        end else if (!busy) begin
            div_q <= '0;
            qtr_q <= 2'd0;
        end else if (div_q == DIV_LAST) begin
            if (!stall) begin
                div_q <= '0;
                qtr_q <= qtr_q + 2'd1;
            end
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: state_d = accept ? S_START : S_IDLE;
            S_START:  if (frame_end) state_d = S_ADDR;
            S_ADDR:   if (frame_end && bit_q == 3'd7) state_d = S_ACK1;
            S_ACK1:   if (frame_end) state_d = sda_s2 ? S_STOP : (rw_q ? S_RDATA : S_WDATA);
            S_WDATA:  if (frame_end && bit_q == 3'd7) state_d = S_WACK;
            S_WACK:   if (frame_end) state_d = S_STOP;
            S_RDATA:  if (frame_end && bit_q == 3'd7) state_d = S_MACK;
            S_MACK:   if (frame_end) state_d = S_STOP;
            S_STOP:   if (frame_end) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase

        case (state_q)
            S_IDLE, S_DONE: ;
            // SDA falls in Q1 with SCL released, SCL follows in Q3.
            S_START: begin
                scl_oe_d = (qtr_q == 2'd3);
                sda_oe_d = (qtr_q != 2'd0);
            end
            // SDA held low through the SCL release, then let go while SCL is high.
            S_STOP: begin
                scl_oe_d = (qtr_q <= 2'd1);
                sda_oe_d = (qtr_q != 2'd3);
            end
            default: begin
                // SCL is pulled low on the last cycle of Q3 so that the SDA update,
                // registered one cycle later in Q0, always lands while SCL is low.
                scl_oe_d = (qtr_q <= 2'd1) || ((qtr_q == 2'd3) && (div_q == DIV_LAST));
                if (state_q == S_ADDR || state_q == S_WDATA) sda_oe_d = !sh_q[7];
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            sh_q     <= 8'h00;
            wdata_q  <= 8'h00;
            rw_q     <= 1'b0;
            bit_q    <= 3'd0;
            rdata    <= 8'h00;
            ack_err  <= 1'b0;
        end else begin
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            if (accept) begin
                sh_q    <= {addr, rw};
                rw_q    <= rw;
                wdata_q <= wdata;
                ack_err <= 1'b0;
                bit_q   <= 3'd0;
            end else if (frame_end) begin
                case (state_q)
                    S_ADDR, S_WDATA: begin
                        sh_q  <= {sh_q[6:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                    end
                    S_RDATA: begin
                        rdata <= {rdata[6:0], sda_s2};
                        bit_q <= bit_q + 3'd1;
                    end
                    S_ACK1: begin
                        if (sda_s2) ack_err <= 1'b1;
                        else        sh_q    <= wdata_q;
                    end
                    S_WACK: if (sda_s2) ack_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a cycle-sampled I2C target model on the bus plus
// a table of directed transactions and hand-written reset/corner sequences.
module tb_i2c_master;
    localparam int D = 8;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic       rw        = 1'b0;
    logic [6:0] addr      = 7'h00;
    logic [7:0] wdata     = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, ack_err;
    wire        SCL, SDA;

    logic tgt_scl = 1'b0;
    logic tgt_sda = 1'b0;
    pullup (SCL);
    pullup (SDA);
    assign SCL = tgt_scl ? 1'b0 : 1'bz;
    assign SDA = tgt_sda ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(D)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .rw(rw),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .ack_err(ack_err), .SCL(SCL), .SDA(SDA)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- target model ----------------
    logic [6:0] tgt_addr   = 7'h01;
    logic [7:0] rd_byte    = 8'h3C;
    bit         stretch_en = 1'b0;

    logic [7:0] bytes_q[$];
    logic       acks_q[$];
    int         n_start = 0, n_stop = 0, n_done = 0;
    int         bitn = -1, byten = 0, hold = 0;
    logic [7:0] msh = 8'h00;
    logic       scl_p = 1'b1, sda_p = 1'b1, sc, sd;
    logic       addr_match = 1'b0, is_read = 1'b0;

    always @(negedge sys_clk) begin
        if (done) n_done++;
        sc = SCL;
        sd = SDA;
        if (hold > 0) begin
            hold--;
            if (hold == 0) tgt_scl = 1'b0;
        end
        if (scl_p && sc && sda_p && !sd) begin
            n_start++;
            bitn = -2;
            byten = 0;
            tgt_sda = 1'b0;
        end else if (scl_p && sc && !sda_p && sd) begin
            n_stop++;
            bitn = -1;
            tgt_sda = 1'b0;
        end else if (!scl_p && sc && bitn >= 0) begin
            if (bitn < 8) msh = {msh[6:0], sd};
            else          acks_q.push_back(sd);
        end else if (scl_p && !sc && bitn != -1) begin
            tgt_sda = 1'b0;
            if (bitn == -2) begin
                bitn = 0;
            end else if (bitn == 7) begin
                bytes_q.push_back(msh);
                if (byten == 0) begin
                    addr_match = (msh[7:1] == tgt_addr);
                    is_read    = msh[0];
                    tgt_sda    = addr_match;
                end else if (!is_read) begin
                    tgt_sda = addr_match;
                end
                bitn = 8;
            end else if (bitn == 8) begin
                if (byten == 0 && stretch_en) begin
                    hold    = 300;
                    tgt_scl = 1'b1;
                end
                byten++;
                bitn = 0;
                if (is_read && addr_match && byten == 1) tgt_sda = !rd_byte[7];
            end else begin
                bitn++;
                if (is_read && addr_match && byten == 1) tgt_sda = !rd_byte[7-bitn];
            end
        end
        scl_p = sc;
        sda_p = sd;
    end

    // ---------------- checking ----------------
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    int nb0, na0, nd0, ns0, np0;

    task automatic run_txn(input logic rw_i, input logic [6:0] a, input logic [7:0] wd,
                           input bit mid, output int cyc);
        nb0 = bytes_q.size();
        na0 = acks_q.size();
        nd0 = n_done;
        ns0 = n_start;
        np0 = n_stop;
        @(negedge sys_clk);
        rw = rw_i; addr = a; wdata = wd; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge sys_clk);
            cyc++;
            start = mid && (cyc == 200);
            if (mid && cyc == 200) wdata = 8'hFF;
        end
        start = 1'b0;
        repeat (20) @(negedge sys_clk);
    endtask

    typedef struct {
        string      name;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        bit         stretch;
        bit         mid;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         nacks;
        logic       a0;
        logic       a1;
        logic       err;
        logic [7:0] rd;
        int         cyc_lo;
        int         cyc_hi;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{"T1_write",   1'b0, 7'h01, 8'hA5, 1'b0, 1'b0, 2, 8'h02, 8'hA5, 2, 1'b0, 1'b0, 1'b0, 8'h00, 80*D, 80*D};
        vecs[1] = '{"T2_read",    1'b1, 7'h01, 8'h00, 1'b0, 1'b0, 2, 8'h03, 8'h3C, 2, 1'b0, 1'b1, 1'b0, 8'h3C, 80*D, 80*D};
        vecs[2] = '{"T3_nack",    1'b0, 7'h55, 8'h12, 1'b0, 1'b0, 1, 8'hAA, 8'h00, 1, 1'b1, 1'b0, 1'b1, 8'h3C, 44*D, 44*D};
        vecs[3] = '{"T4_midstrt", 1'b0, 7'h01, 8'hA5, 1'b0, 1'b1, 2, 8'h02, 8'hA5, 2, 1'b0, 1'b0, 1'b0, 8'h3C, 80*D, 80*D};
        vecs[4] = '{"T5_stretch", 1'b0, 7'h01, 8'h5A, 1'b1, 1'b0, 2, 8'h02, 8'h5A, 2, 1'b0, 1'b0, 1'b0, 8'h3C, 80*D+250, 80*D+320};

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.ack_err", ack_err, 0);
        chk("rst.rdata", rdata, 8'h00);
        chk("rst.SCL", SCL, 1);
        chk("rst.SDA", SDA, 1);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 5; i++) begin
            stretch_en = vecs[i].stretch;
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].mid, cyc);
            stretch_en = 1'b0;
            chk_rng({vecs[i].name, ".cycles"}, cyc, vecs[i].cyc_lo, vecs[i].cyc_hi);
            chk({vecs[i].name, ".nbytes"}, bytes_q.size() - nb0, vecs[i].nbytes);
            if (bytes_q.size() > nb0)
                chk({vecs[i].name, ".byte0"}, bytes_q[nb0], vecs[i].b0);
            if (vecs[i].nbytes > 1 && bytes_q.size() > nb0 + 1)
                chk({vecs[i].name, ".byte1"}, bytes_q[nb0+1], vecs[i].b1);
            chk({vecs[i].name, ".nacks"}, acks_q.size() - na0, vecs[i].nacks);
            if (acks_q.size() > na0)
                chk({vecs[i].name, ".ack0"}, acks_q[na0], vecs[i].a0);
            if (vecs[i].nacks > 1 && acks_q.size() > na0 + 1)
                chk({vecs[i].name, ".ack1"}, acks_q[na0+1], vecs[i].a1);
            chk({vecs[i].name, ".ack_err"}, ack_err, vecs[i].err);
            chk({vecs[i].name, ".rdata"}, rdata, vecs[i].rd);
            chk({vecs[i].name, ".done_pulses"}, n_done - nd0, 1);
            chk({vecs[i].name, ".starts"}, n_start - ns0, 1);
            chk({vecs[i].name, ".stops"}, n_stop - np0, 1);
            chk({vecs[i].name, ".busy_end"}, busy, 0);
        end

        // T6: reset in the middle of WDATA bit 3 (Q1, SCL low, data bit 0)
        @(negedge sys_clk);
        rw = 1'b0; addr = 7'h01; wdata = 8'hA5; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (13*4*D + D + D/2) @(negedge sys_clk);
        chk("T6.busy_mid", busy, 1);
        chk("T6.SCL_mid", SCL, 0);
        chk("T6.SDA_mid", SDA, 0);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("T6.SCL_rst", SCL, 1);
        chk("T6.SDA_rst", SDA, 1);
        chk("T6.busy_rst", busy, 0);
        chk("T6.done_rst", done, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        run_txn(1'b0, 7'h01, 8'hC3, 1'b0, cyc);
        chk_rng("T6.cycles", cyc, 80*D, 80*D);
        chk("T6.nbytes", bytes_q.size() - nb0, 2);
        if (bytes_q.size() > nb0 + 1) begin
            chk("T6.byte0", bytes_q[nb0], 8'h02);
            chk("T6.byte1", bytes_q[nb0+1], 8'hC3);
        end
        chk("T6.ack_err", ack_err, 0);
        chk("T6.rdata", rdata, 8'h00);
        chk("T6.done_pulses", n_done - nd0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
